rr_arb_32b: RTL
===============

Name: rr_arb_32b

Overview:
- Round-robin arbiter that shares one resource among up to 32 requesters.
- Selection uses a masked lowest-index priority encoder: the search starts at a rotating pointer and wraps.
- The grant is held until the owner signals done or drops its request.
- Sits in front of any shared unit: pe_32b-style encoder banks, memories, buses.

Parameters:
- N, 32, number of requesters (power of two, 2..32).
- HOLD_MAX, 16, maximum grant length in cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- req  input  N  request vector; bit i = requester i.
- done  input  1  owner finished; honoured only while gnt_val=1.
- gnt  output  N  one-hot grant vector; all zero when idle.
- gnt_val  output  1  a grant is active.
- gnt_id  output  $clog2(N)+1  index of the owner; 0 when idle.
- preempt  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (rst=0, asynchronous): gnt=0, gnt_val=0, gnt_id=0, preempt=0, ptr=0, state=IDLE.
  - Applies immediately, including mid-grant. No grant survives reset.
- States: IDLE and GRANT.
- IDLE:
  - If req!=0, the next rising edge enters GRANT and registers the winner.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req==0, stay in IDLE.
- Winner selection:
  - masked = req & ~((1<<ptr)-1).
  - If masked!=0, the winner is the lowest set bit of masked.
  - Otherwise the winner is the lowest set bit of req (wrap-around).
- GRANT:
  - gnt = 1<<gnt_id, gnt_val=1. Grant outputs come straight from registers.
- Release occurs on the edge where done=1, or where req[gnt_id]=0.
  - At that edge: state goes to IDLE, gnt=0, gnt_val=0, gnt_id=0, and ptr=(owner+1) mod N.
  - Exactly one idle bubble cycle separates consecutive grants.
  - The next grant is evaluated in the bubble cycle using the new ptr.
- Requests from other requesters arriving during GRANT are never preemptive without the optional feature.
- done asserted in IDLE is ignored.
- done and req drop in the same cycle produce one release; ptr advances once.
- req changing during the bubble cycle: the value sampled at the bubble edge decides.
- ptr width is $clog2(N); the increment wraps from N-1 to 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When gnt_val has been high for HOLD_MAX cycles, a forced release happens on the next edge, identical to a done release (ptr=owner+1).
  - preempt=1 for exactly the cycle after that edge.
  - done and the timeout on the same edge count as a normal release: preempt=0.
- Undefined: no counter is built, preempt is tied 0, and a grant can be held indefinitely.

Decomposition:
- Package arb_pkg:
  - ARB_N=32.
  - ARB_ID_W=$clog2(ARB_N)+1.
  - State type {ST_IDLE, ST_GRANT}.
  - ARB_HOLD_MAX=16.
- Sub-module pe_mask_32b: combinational lowest-index priority encoder.
  - Inputs: vector in, pointer ptr.
  - Outputs: val and out, in the same encoding as pe_32b.
  - Instantiated once. rr_arb_32b keeps all state, ptr and registers.

Test Plan:
1. Reset and idle:
   - rst=0 with req=32'hFFFF_FFFF -> gnt=0, gnt_val=0, gnt_id=0.
   - Release rst, req=0 -> remains idle for 10 cycles.
2. Single requester:
   - req=32'h0000_0010 -> next edge gnt=32'h10, gnt_id=4, gnt_val=1.
   - Pulse done -> next edge gnt_val=0. Next grant to 4 again after the bubble (wrap from ptr=5).
3. Rotation:
   - req=32'h8000_0201 held, done pulsed on each grant -> grant order 0, 9, 31, 0.
   - gnt_val low exactly one cycle between grants.
4. Wrap and drop:
   - After a grant to 30, req=32'h0000_0003 -> grant to 0.
   - Drop req[0] mid-grant -> release next edge, then grant to 1.
5. Async reset mid-grant:
   - Grant to 9 active, rst=0 between edges -> outputs zero immediately.
   - After reset, req=32'h200 -> grant to 9 (ptr=0).
6. With ARB_TIMEOUT_EN, HOLD_MAX=16:
   - req=32'h1, done never asserted -> gnt_val high 16 cycles, then a forced release with preempt pulsed for 1 cycle, then a regrant to 0 after the bubble.
   - Without the macro: grant held for 100 cycles, preempt=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin arbiter.
package arb_pkg;

  localparam int ARB_N        = 32;
  localparam int ARB_ID_W     = $clog2(ARB_N) + 1;
  localparam int ARB_HOLD_MAX = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/pe_mask_32b.sv
// Masked lowest-index priority encoder: search starts at ptr and wraps to bit 0.
// Purely combinational; out is 0 and val is 0 when no input bit is set.
module pe_mask_32b #(
  parameter int N = 32
) (
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 val,
  output logic [$clog2(N):0]   out
);

  localparam int ID_W = $clog2(N) + 1;

  logic [N-1:0] masked;
  logic [N-1:0] sel;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = in[i] && (i >= int'(ptr));
    end
    // Nothing at or above ptr: wrap and take the lowest request overall.
    sel = (|masked) ? masked : in;
    val = |in;
    out = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        out = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arb_32b.sv
// Round-robin arbiter for N requesters; grant held until done or request drop, 1-cycle bubble between grants.
// Optional hold-time limit with preempt pulse when ARB_TIMEOUT_EN is defined.
module rr_arb_32b
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int HOLD_MAX = ARB_HOLD_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_val,
  output logic [$clog2(N):0]   gnt_id,
  output logic                 preempt
);

  localparam int PTR_W = $clog2(N);
  localparam int ID_W  = $clog2(N) + 1;

  if (N < 2 || N > 32 || HOLD_MAX < 1) begin : g_param_check
    $error("rr_arb_32b: N must be 2..32 and HOLD_MAX at least 1");
  end

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [N-1:0]       gnt_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic               pe_val;
  logic [ID_W-1:0]    pe_out;
  logic [PTR_W-1:0]   owner;
  logic               timeout;
  logic               release_now;

  pe_mask_32b #(.N(N)) u_pe (
    .in  (req),
    .ptr (ptr),
    .val (pe_val),
    .out (pe_out)
  );

  assign owner       = gnt_id[PTR_W-1:0];
  assign release_now = done || !req[owner] || timeout;
  assign gnt_val     = (state == ST_GRANT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    case (state)
      ST_IDLE: begin
        if (pe_val) begin
          state_nxt = ST_GRANT;
          id_nxt    = pe_out;
          gnt_nxt   = N'(1) << pe_out;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_nxt = ST_IDLE;
          id_nxt    = '0;
          gnt_nxt   = '0;
          // N is a power of two, so the add wraps N-1 -> 0 on its own.
          ptr_nxt   = owner + PTR_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        id_nxt    = '0;
        gnt_nxt   = '0;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             preempt_q;

  // hold_cnt counts completed grant cycles; the last permitted cycle is HOLD_MAX-1.
  assign timeout = (state == ST_GRANT) && (hold_cnt == CNT_W'(HOLD_MAX - 1));
  assign preempt = preempt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_cnt  <= (state == ST_GRANT && !release_now) ? hold_cnt + CNT_W'(1) : '0;
      preempt_q <= timeout && !done && req[owner];
    end
  end
`else
  assign timeout = 1'b0;
  assign preempt = 1'b0;
`endif

endmodule
